// File: rtl/axi_lite_slave_regfile.sv
// AXI-lite target holding NREGS 64-bit registers with independent write/read FSMs.
// Define AXI_LITE_REGFILE_PROT_CHECK_EN to reject unprivileged access to the upper half.
module axi_lite_slave_regfile #(
    parameter int          NREGS     = 16,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic [63:0] s2m_aw_addr,
    input  logic        s2m_aw_valid,
    input  logic [3:0]  s2m_aw_id,
    input  logic [2:0]  s2m_aw_prot,
    output logic        s2m_aw_ready,
    input  logic [63:0] s2m_wdata,
    input  logic        s2m_wvalid,
    input  logic [8:0]  s2m_wstrb,
    output logic        s2m_wready,
    output logic        s2m_bvalid,
    output logic [3:0]  s2m_bid,
    output logic [1:0]  s2m_bresp,
    input  logic        s2m_bready,
    input  logic [63:0] s2m_ar_addr,
    input  logic        s2m_ar_valid,
    input  logic [3:0]  s2m_ar_id,
    input  logic [2:0]  s2m_ar_prot,
    output logic        s2m_ar_ready,
    output logic [63:0] s2m_rdata,
    output logic        s2m_rvalid,
    output logic [3:0]  s2m_rid,
    output logic [1:0]  s2m_rresp,
    input  logic        s2m_rready
);

    localparam int          IW   = $clog2(NREGS);
    localparam logic [63:0] SPAN = 64'(NREGS) << 3;

    typedef enum logic { WR_IDLE, WR_RESP } wr_state_t;
    typedef enum logic { RD_IDLE, RD_RESP } rd_state_t;

    // Returns {error, register index}.
    function automatic logic [IW:0] decode(
        input logic [63:0] addr,
        input logic [2:0]  prot
    );
        logic [63:0] off;
        logic        err;
        off = addr - BASE_ADDR;
        err = (addr < BASE_ADDR) || (off >= SPAN);
`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
        err = err || (off[IW+2] && !prot[0]);
`else
        err = err || (prot[0] && 1'b0);
`endif
        return {err, off[IW+2:3]};
    endfunction

    logic [63:0] regs [NREGS];

    wr_state_t   wr_state, wr_state_n;
    logic        aw_held, aw_held_n;
    logic        w_held, w_held_n;
    logic [63:0] aw_addr_q;
    logic [3:0]  aw_id_q;
    logic [2:0]  aw_prot_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        aw_ready_n, w_ready_n;
    logic        bvalid_n;
    logic [3:0]  bid_n;
    logic [1:0]  bresp_n;

    logic        aw_hs, w_hs, aw_have, w_have, commit;
    logic [63:0] wa, wd;
    logic [7:0]  ws;
    logic [3:0]  wid;
    logic [2:0]  wp;
    logic        w_err;
    logic [IW-1:0] w_idx;

    rd_state_t   rd_state, rd_state_n;
    logic        ar_ready_n, rvalid_n;
    logic [63:0] rdata_n;
    logic [3:0]  rid_n;
    logic [1:0]  rresp_n;
    logic        ar_hs, r_err;
    logic [IW-1:0] r_idx;

    logic unused;
    assign unused = ^{s2m_wstrb[8], s2m_aw_prot[2:1], s2m_ar_prot[2:1]};

    // A beat completing this cycle is used directly, so the commit needs no extra cycle.
    assign aw_hs   = s2m_aw_valid & s2m_aw_ready;
    assign w_hs    = s2m_wvalid & s2m_wready;
    assign aw_have = aw_held | aw_hs;
    assign w_have  = w_held | w_hs;
    assign commit  = (wr_state == WR_IDLE) & aw_have & w_have;
    assign wa      = aw_hs ? s2m_aw_addr : aw_addr_q;
    assign wid     = aw_hs ? s2m_aw_id : aw_id_q;
    assign wp      = aw_hs ? s2m_aw_prot : aw_prot_q;
    assign wd      = w_hs ? s2m_wdata : wdata_q;
    assign ws      = w_hs ? s2m_wstrb[7:0] : wstrb_q;
    assign {w_err, w_idx} = decode(wa, wp);

    assign ar_hs = s2m_ar_valid & s2m_ar_ready;
    assign {r_err, r_idx} = decode(s2m_ar_addr, s2m_ar_prot);

    always_comb begin
        wr_state_n = wr_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        aw_ready_n = s2m_aw_ready;
        w_ready_n  = s2m_wready;
        bvalid_n   = s2m_bvalid;
        bid_n      = s2m_bid;
        bresp_n    = s2m_bresp;
        unique case (wr_state)
            WR_IDLE: begin
                if (commit) begin
                    wr_state_n = WR_RESP;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                    aw_ready_n = 1'b0;
                    w_ready_n  = 1'b0;
                    bvalid_n   = 1'b1;
                    bid_n      = wid;
                    bresp_n    = w_err ? 2'b10 : 2'b00;
                end else begin
                    aw_held_n  = aw_have;
                    w_held_n   = w_have;
                    aw_ready_n = !aw_have;
                    w_ready_n  = !w_have;
                end
            end
            WR_RESP: begin
                if (s2m_bready) begin
                    wr_state_n = WR_IDLE;
                    aw_ready_n = 1'b1;
                    w_ready_n  = 1'b1;
                    bvalid_n   = 1'b0;
                end
            end
            default: wr_state_n = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_n = rd_state;
        ar_ready_n = s2m_ar_ready;
        rvalid_n   = s2m_rvalid;
        rdata_n    = s2m_rdata;
        rid_n      = s2m_rid;
        rresp_n    = s2m_rresp;
        unique case (rd_state)
            RD_IDLE: begin
                ar_ready_n = 1'b1;
                if (ar_hs) begin
                    rd_state_n = RD_RESP;
                    ar_ready_n = 1'b0;
                    rvalid_n   = 1'b1;
                    rdata_n    = r_err ? 64'h0 : regs[r_idx];
                    rid_n      = s2m_ar_id;
                    rresp_n    = r_err ? 2'b10 : 2'b00;
                end
            end
            RD_RESP: begin
                if (s2m_rready) begin
                    rd_state_n = RD_IDLE;
                    ar_ready_n = 1'b1;
                    rvalid_n   = 1'b0;
                end
            end
            default: rd_state_n = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            wr_state     <= WR_IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_q    <= '0;
            aw_id_q      <= '0;
            aw_prot_q    <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            s2m_aw_ready <= 1'b0;
            s2m_wready   <= 1'b0;
            s2m_bvalid   <= 1'b0;
            s2m_bid      <= '0;
            s2m_bresp    <= '0;
        end else begin
            wr_state     <= wr_state_n;
            aw_held      <= aw_held_n;
            w_held       <= w_held_n;
            s2m_aw_ready <= aw_ready_n;
            s2m_wready   <= w_ready_n;
            s2m_bvalid   <= bvalid_n;
            s2m_bid      <= bid_n;
            s2m_bresp    <= bresp_n;
            if (aw_hs) begin
                aw_addr_q <= s2m_aw_addr;
                aw_id_q   <= s2m_aw_id;
                aw_prot_q <= s2m_aw_prot;
            end
            if (w_hs) begin
                wdata_q <= s2m_wdata;
                wstrb_q <= s2m_wstrb[7:0];
            end
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            rd_state     <= RD_IDLE;
            s2m_ar_ready <= 1'b0;
            s2m_rvalid   <= 1'b0;
            s2m_rdata    <= '0;
            s2m_rid      <= '0;
            s2m_rresp    <= '0;
        end else begin
            rd_state     <= rd_state_n;
            s2m_ar_ready <= ar_ready_n;
            s2m_rvalid   <= rvalid_n;
            s2m_rdata    <= rdata_n;
            s2m_rid      <= rid_n;
            s2m_rresp    <= rresp_n;
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (commit && !w_err) begin
            for (int k = 0; k < 8; k++) begin
                if (ws[k]) regs[w_idx][8*k +: 8] <= wd[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed self-checking bench for axi_lite_slave_regfile (NREGS=16, BASE_ADDR=0).
module tb_axi_lite_slave_regfile;

    logic        aclk = 1'b0;
    logic        arst_n = 1'b0;
    logic [63:0] s2m_aw_addr = '0;
    logic        s2m_aw_valid = 1'b0;
    logic [3:0]  s2m_aw_id = '0;
    logic [2:0]  s2m_aw_prot = '0;
    logic        s2m_aw_ready;
    logic [63:0] s2m_wdata = '0;
    logic        s2m_wvalid = 1'b0;
    logic [8:0]  s2m_wstrb = '0;
    logic        s2m_wready;
    logic        s2m_bvalid;
    logic [3:0]  s2m_bid;
    logic [1:0]  s2m_bresp;
    logic        s2m_bready = 1'b0;
    logic [63:0] s2m_ar_addr = '0;
    logic        s2m_ar_valid = 1'b0;
    logic [3:0]  s2m_ar_id = '0;
    logic [2:0]  s2m_ar_prot = '0;
    logic        s2m_ar_ready;
    logic [63:0] s2m_rdata;
    logic        s2m_rvalid;
    logic [3:0]  s2m_rid;
    logic [1:0]  s2m_rresp;
    logic        s2m_rready = 1'b0;

    int passed = 0;
    int total = 0;

    axi_lite_slave_regfile #(.NREGS(16), .BASE_ADDR(64'h0)) dut (
        .aclk(aclk), .arst_n(arst_n),
        .s2m_aw_addr(s2m_aw_addr), .s2m_aw_valid(s2m_aw_valid),
        .s2m_aw_id(s2m_aw_id), .s2m_aw_prot(s2m_aw_prot),
        .s2m_aw_ready(s2m_aw_ready),
        .s2m_wdata(s2m_wdata), .s2m_wvalid(s2m_wvalid),
        .s2m_wstrb(s2m_wstrb), .s2m_wready(s2m_wready),
        .s2m_bvalid(s2m_bvalid), .s2m_bid(s2m_bid),
        .s2m_bresp(s2m_bresp), .s2m_bready(s2m_bready),
        .s2m_ar_addr(s2m_ar_addr), .s2m_ar_valid(s2m_ar_valid),
        .s2m_ar_id(s2m_ar_id), .s2m_ar_prot(s2m_ar_prot),
        .s2m_ar_ready(s2m_ar_ready),
        .s2m_rdata(s2m_rdata), .s2m_rvalid(s2m_rvalid),
        .s2m_rid(s2m_rid), .s2m_rresp(s2m_rresp),
        .s2m_rready(s2m_rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(
        input  logic [63:0] a,
        input  logic [63:0] d,
        input  logic [8:0]  s,
        input  logic [3:0]  id,
        input  logic [2:0]  p,
        output logic [1:0]  resp,
        output logic [3:0]  bid_o
    );
        bit aw_p, w_p, hs_aw, hs_w;
        int n;
        s2m_aw_addr = a; s2m_aw_id = id; s2m_aw_prot = p;
        s2m_wdata = d; s2m_wstrb = s;
        s2m_aw_valid = 1'b1; s2m_wvalid = 1'b1;
        aw_p = 1'b1; w_p = 1'b1; n = 0;
        while ((aw_p || w_p) && n < 20) begin
            hs_aw = aw_p && s2m_aw_ready;
            hs_w  = w_p && s2m_wready;
            tick(); n++;
            if (hs_aw) begin aw_p = 1'b0; s2m_aw_valid = 1'b0; end
            if (hs_w) begin w_p = 1'b0; s2m_wvalid = 1'b0; end
        end
        n = 0;
        while (!s2m_bvalid && n < 20) begin tick(); n++; end
        resp = s2m_bresp; bid_o = s2m_bid;
        if (!s2m_bvalid) begin
            total++;
            $display("FAIL wr_timeout: bvalid=%b required 1", s2m_bvalid);
            s2m_aw_valid = 1'b0; s2m_wvalid = 1'b0;
            resp = 2'bxx;
        end else begin
            s2m_bready = 1'b1; tick(); s2m_bready = 1'b0;
        end
    endtask

    task automatic axi_read(
        input  logic [63:0] a,
        input  logic [3:0]  id,
        input  logic [2:0]  p,
        output logic [63:0] data,
        output logic [1:0]  resp,
        output logic [3:0]  rid_o
    );
        bit hs;
        int n;
        s2m_ar_addr = a; s2m_ar_id = id; s2m_ar_prot = p;
        s2m_ar_valid = 1'b1; n = 0; hs = 1'b0;
        while (!hs && n < 20) begin
            hs = s2m_ar_ready;
            tick(); n++;
        end
        s2m_ar_valid = 1'b0;
        n = 0;
        while (!s2m_rvalid && n < 20) begin tick(); n++; end
        data = s2m_rdata; resp = s2m_rresp; rid_o = s2m_rid;
        if (!s2m_rvalid) begin
            total++;
            $display("FAIL rd_timeout: rvalid=%b required 1", s2m_rvalid);
            resp = 2'bxx;
        end else begin
            s2m_rready = 1'b1; tick(); s2m_rready = 1'b0;
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        tick(); tick();
        total++;
        if ({s2m_aw_ready, s2m_wready, s2m_ar_ready, s2m_bvalid, s2m_rvalid} !== 5'b00000)
            $display("FAIL reset_outputs: got %b required 00000",
                {s2m_aw_ready, s2m_wready, s2m_ar_ready, s2m_bvalid, s2m_rvalid});
        else passed++;
        arst_n = 1'b1;
        tick();
        total++;
        if ({s2m_aw_ready, s2m_wready, s2m_ar_ready, s2m_bvalid, s2m_rvalid} !== 5'b11100)
            $display("FAIL reset_release: got %b required 11100",
                {s2m_aw_ready, s2m_wready, s2m_ar_ready, s2m_bvalid, s2m_rvalid});
        else passed++;
    endtask

    task automatic test_same_cycle();
        logic [63:0] d; logic [1:0] r; logic [3:0] id;
        s2m_aw_addr = 64'h10; s2m_aw_id = 4'h3; s2m_aw_prot = 3'b001;
        s2m_wdata = 64'hDEADBEEF_CAFEF00D; s2m_wstrb = 9'h0FF;
        s2m_aw_valid = 1'b1; s2m_wvalid = 1'b1;
        tick();
        s2m_aw_valid = 1'b0; s2m_wvalid = 1'b0;
        total++;
        if ({s2m_bvalid, s2m_bid, s2m_bresp, s2m_aw_ready, s2m_wready} !== {1'b1, 4'h3, 2'b00, 2'b00})
            $display("FAIL same_cycle_b: got %b required %b",
                {s2m_bvalid, s2m_bid, s2m_bresp, s2m_aw_ready, s2m_wready}, {1'b1, 4'h3, 2'b00, 2'b00});
        else passed++;
        tick();
        total++;
        if ({s2m_bvalid, s2m_bid} !== {1'b1, 4'h3})
            $display("FAIL b_hold: got %b required %b", {s2m_bvalid, s2m_bid}, {1'b1, 4'h3});
        else passed++;
        s2m_bready = 1'b1; tick(); s2m_bready = 1'b0;
        total++;
        if ({s2m_bvalid, s2m_aw_ready, s2m_wready} !== 3'b011)
            $display("FAIL b_done_readys: got %b required 011", {s2m_bvalid, s2m_aw_ready, s2m_wready});
        else passed++;
        axi_read(64'h10, 4'h1, 3'b001, d, r, id);
        total++;
        if ({d, r, id} !== {64'hDEADBEEF_CAFEF00D, 2'b00, 4'h1})
            $display("FAIL same_cycle_read: got %h/%b/%h required deadbeefcafef00d/00/1", d, r, id);
        else passed++;
    endtask

    task automatic test_w_first();
        logic [63:0] d; logic [1:0] r; logic [3:0] id;
        s2m_wdata = 64'h1122334455667788; s2m_wstrb = 9'h00F; s2m_wvalid = 1'b1;
        tick();
        s2m_wvalid = 1'b0;
        total++;
        if ({s2m_wready, s2m_aw_ready, s2m_bvalid} !== 3'b010)
            $display("FAIL w_first_ready: got %b required 010", {s2m_wready, s2m_aw_ready, s2m_bvalid});
        else passed++;
        tick(); tick();
        s2m_aw_addr = 64'h18; s2m_aw_id = 4'h5; s2m_aw_prot = 3'b001; s2m_aw_valid = 1'b1;
        tick();
        s2m_aw_valid = 1'b0;
        total++;
        if ({s2m_bvalid, s2m_bid, s2m_bresp} !== {1'b1, 4'h5, 2'b00})
            $display("FAIL w_first_b: got %b required %b", {s2m_bvalid, s2m_bid, s2m_bresp}, {1'b1, 4'h5, 2'b00});
        else passed++;
        s2m_bready = 1'b1; tick(); s2m_bready = 1'b0;
        axi_read(64'h18, 4'h2, 3'b001, d, r, id);
        total++;
        if ({d, r} !== {64'h0000000055667788, 2'b00})
            $display("FAIL w_first_read: got %h/%b required 0000000055667788/00", d, r);
        else passed++;
    endtask

    task automatic test_aw_first();
        logic [63:0] d; logic [1:0] r; logic [3:0] id;
        s2m_aw_addr = 64'h20; s2m_aw_id = 4'h6; s2m_aw_prot = 3'b001; s2m_aw_valid = 1'b1;
        tick();
        s2m_aw_valid = 1'b0;
        total++;
        if ({s2m_aw_ready, s2m_wready, s2m_bvalid} !== 3'b010)
            $display("FAIL aw_first_ready: got %b required 010", {s2m_aw_ready, s2m_wready, s2m_bvalid});
        else passed++;
        tick();
        s2m_wdata = 64'hAABBCCDD11223344; s2m_wstrb = 9'h1F0; s2m_wvalid = 1'b1;
        tick();
        s2m_wvalid = 1'b0;
        total++;
        if ({s2m_bvalid, s2m_bid, s2m_bresp} !== {1'b1, 4'h6, 2'b00})
            $display("FAIL aw_first_b: got %b required %b", {s2m_bvalid, s2m_bid, s2m_bresp}, {1'b1, 4'h6, 2'b00});
        else passed++;
        s2m_bready = 1'b1; tick(); s2m_bready = 1'b0;
        axi_read(64'h20, 4'h3, 3'b001, d, r, id);
        total++;
        if (d !== 64'hAABBCCDD00000000)
            $display("FAIL strobe_upper: got %h required aabbccdd00000000", d);
        else passed++;
    endtask

    task automatic test_out_of_range();
        logic [63:0] d; logic [1:0] r; logic [3:0] id;
        axi_write(64'h80, 64'hFFFFFFFF_FFFFFFFF, 9'h1FF, 4'h7, 3'b001, r, id);
        total++;
        if ({r, id} !== {2'b10, 4'h7})
            $display("FAIL oor_write: got %b/%h required 10/7", r, id);
        else passed++;
        axi_read(64'h80, 4'h4, 3'b001, d, r, id);
        total++;
        if ({d, r} !== {64'h0, 2'b10})
            $display("FAIL oor_read: got %h/%b required 0/10", d, r);
        else passed++;
        axi_read(64'h10, 4'h4, 3'b001, d, r, id);
        total++;
        if (d !== 64'hDEADBEEF_CAFEF00D)
            $display("FAIL oor_no_modify: got %h required deadbeefcafef00d", d);
        else passed++;
        axi_write(64'h78, 64'h5A5A5A5A_A5A5A5A5, 9'h0FF, 4'h8, 3'b001, r, id);
        total++;
        if (r !== 2'b00)
            $display("FAIL last_reg_write: got %b required 00", r);
        else passed++;
        axi_read(64'h7F, 4'h5, 3'b001, d, r, id);
        total++;
        if ({d, r, id} !== {64'h5A5A5A5A_A5A5A5A5, 2'b00, 4'h5})
            $display("FAIL last_reg_read: got %h/%b/%h required 5a5a5a5aa5a5a5a5/00/5", d, r, id);
        else passed++;
    endtask

    task automatic test_read_backpressure();
        logic [63:0] d; logic [1:0] r; logic [3:0] id;
        s2m_ar_addr = 64'h18; s2m_ar_id = 4'hA; s2m_ar_prot = 3'b001; s2m_ar_valid = 1'b1;
        tick();
        s2m_ar_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({s2m_rvalid, s2m_rid, s2m_rdata, s2m_ar_ready} !== {1'b1, 4'hA, 64'h0000000055667788, 1'b0})
                $display("FAIL r_stall_%0d: got %b/%h/%h/%b required 1/a/0000000055667788/0",
                    i, s2m_rvalid, s2m_rid, s2m_rdata, s2m_ar_ready);
            else passed++;
            tick();
        end
        axi_write(64'h28, 64'h0F0F0F0F_0F0F0F0F, 9'h0FF, 4'h2, 3'b001, r, id);
        total++;
        if ({r, id} !== {2'b00, 4'h2})
            $display("FAIL write_during_stall: got %b/%h required 00/2", r, id);
        else passed++;
        total++;
        if ({s2m_rvalid, s2m_rdata} !== {1'b1, 64'h0000000055667788})
            $display("FAIL r_still_held: got %b/%h required 1/0000000055667788", s2m_rvalid, s2m_rdata);
        else passed++;
        s2m_rready = 1'b1; tick(); s2m_rready = 1'b0;
        total++;
        if ({s2m_rvalid, s2m_ar_ready} !== 2'b01)
            $display("FAIL r_release: got %b required 01", {s2m_rvalid, s2m_ar_ready});
        else passed++;
        axi_read(64'h28, 4'h6, 3'b001, d, r, id);
        total++;
        if (d !== 64'h0F0F0F0F_0F0F0F0F)
            $display("FAIL stall_write_read: got %h required 0f0f0f0f0f0f0f0f", d);
        else passed++;
    endtask

    task automatic test_collision();
        logic [63:0] d; logic [1:0] r; logic [3:0] id;
        s2m_aw_addr = 64'h10; s2m_aw_id = 4'h1; s2m_aw_prot = 3'b001;
        s2m_wdata = 64'h01234567_89ABCDEF; s2m_wstrb = 9'h0FF;
        s2m_ar_addr = 64'h10; s2m_ar_id = 4'h9; s2m_ar_prot = 3'b001;
        s2m_aw_valid = 1'b1; s2m_wvalid = 1'b1; s2m_ar_valid = 1'b1;
        tick();
        s2m_aw_valid = 1'b0; s2m_wvalid = 1'b0; s2m_ar_valid = 1'b0;
        total++;
        if ({s2m_rvalid, s2m_rid, s2m_rdata} !== {1'b1, 4'h9, 64'hDEADBEEF_CAFEF00D})
            $display("FAIL collision_old: got %b/%h/%h required 1/9/deadbeefcafef00d",
                s2m_rvalid, s2m_rid, s2m_rdata);
        else passed++;
        total++;
        if ({s2m_bvalid, s2m_bresp} !== 3'b100)
            $display("FAIL collision_b: got %b required 100", {s2m_bvalid, s2m_bresp});
        else passed++;
        s2m_bready = 1'b1; s2m_rready = 1'b1; tick();
        s2m_bready = 1'b0; s2m_rready = 1'b0;
        axi_read(64'h10, 4'h7, 3'b001, d, r, id);
        total++;
        if (d !== 64'h01234567_89ABCDEF)
            $display("FAIL collision_new: got %h required 0123456789abcdef", d);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] d; logic [1:0] r; logic [3:0] id;
        s2m_wdata = 64'hFFFFFFFF_FFFFFFFF; s2m_wstrb = 9'h0FF; s2m_wvalid = 1'b1;
        tick();
        s2m_wvalid = 1'b0;
        s2m_ar_addr = 64'h10; s2m_ar_id = 4'hB; s2m_ar_prot = 3'b001; s2m_ar_valid = 1'b1;
        tick();
        s2m_ar_valid = 1'b0;
        arst_n = 1'b0;
        #2;
        total++;
        if ({s2m_aw_ready, s2m_wready, s2m_ar_ready, s2m_bvalid, s2m_rvalid} !== 5'b00000)
            $display("FAIL async_reset: got %b required 00000",
                {s2m_aw_ready, s2m_wready, s2m_ar_ready, s2m_bvalid, s2m_rvalid});
        else passed++;
        arst_n = 1'b1;
        tick();
        s2m_aw_addr = 64'h30; s2m_aw_id = 4'h1; s2m_aw_prot = 3'b001; s2m_aw_valid = 1'b1;
        tick();
        s2m_aw_valid = 1'b0;
        tick();
        total++;
        if ({s2m_bvalid, s2m_rvalid, s2m_wready} !== 3'b001)
            $display("FAIL stale_beats: got %b required 001", {s2m_bvalid, s2m_rvalid, s2m_wready});
        else passed++;
        s2m_wdata = 64'h00000000_000000A5; s2m_wstrb = 9'h001; s2m_wvalid = 1'b1;
        tick();
        s2m_wvalid = 1'b0;
        s2m_bready = 1'b1; tick(); s2m_bready = 1'b0;
        axi_read(64'h10, 4'h2, 3'b001, d, r, id);
        total++;
        if (d !== 64'h0)
            $display("FAIL regs_cleared: got %h required 0", d);
        else passed++;
        axi_read(64'h30, 4'h3, 3'b001, d, r, id);
        total++;
        if ({d, r} !== {64'hA5, 2'b00})
            $display("FAIL post_reset_write: got %h/%b required a5/00", d, r);
        else passed++;
    endtask

`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
    task automatic test_prot();
        logic [63:0] d; logic [1:0] r; logic [3:0] id;
        axi_write(64'h40, 64'h0000CAFE, 9'h0FF, 4'h3, 3'b000, r, id);
        total++;
        if (r !== 2'b10) $display("FAIL prot_write_unpriv: got %b required 10", r);
        else passed++;
        axi_read(64'h40, 4'h1, 3'b001, d, r, id);
        total++;
        if ({d, r} !== {64'h0, 2'b00})
            $display("FAIL prot_unchanged: got %h/%b required 0/00", d, r);
        else passed++;
        axi_write(64'h40, 64'h0000CAFE, 9'h0FF, 4'h3, 3'b001, r, id);
        total++;
        if (r !== 2'b00) $display("FAIL prot_write_priv: got %b required 00", r);
        else passed++;
        axi_read(64'h40, 4'h1, 3'b001, d, r, id);
        total++;
        if ({d, r} !== {64'hCAFE, 2'b00})
            $display("FAIL prot_stored: got %h/%b required cafe/00", d, r);
        else passed++;
        axi_read(64'h40, 4'h1, 3'b000, d, r, id);
        total++;
        if ({d, r} !== {64'h0, 2'b10})
            $display("FAIL prot_read_unpriv: got %h/%b required 0/10", d, r);
        else passed++;
        axi_read(64'h30, 4'h1, 3'b000, d, r, id);
        total++;
        if ({d, r} !== {64'hA5, 2'b00})
            $display("FAIL prot_low_half: got %h/%b required a5/00", d, r);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_same_cycle();
        test_w_first();
        test_aw_first();
        test_out_of_range();
        test_read_backpressure();
        test_collision();
        test_reset_mid();
`ifdef AXI_LITE_REGFILE_PROT_CHECK_EN
        test_prot();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
